// File: rtl/gobou_net_arb_pkg.sv
// rtl/gobou_net_arb_pkg.sv - shared widths and owner encodings for the gobou net-parameter arbiter
package gobou_net_arb_pkg;

  localparam int NINJIN_DWIDTH     = 16;
  localparam int GOBOU_NETSIZE_DEF = 12;
  localparam int STARVE_MAX_DEF    = 15;

  // Also decoded by the core sequencer, so the values are fixed.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_HOST = 2'd1,
    OWN_CORE = 2'd2
  } owner_e;

endpackage

// File: rtl/gobou_net_arb.sv
// rtl/gobou_net_arb.sv - host/core arbiter in front of the gobou net-parameter RAM
module gobou_net_arb
  import gobou_net_arb_pkg::*;
#(
  parameter int DWIDTH        = NINJIN_DWIDTH,
  parameter int GOBOU_NETSIZE = GOBOU_NETSIZE_DEF,
  parameter int STARVE_MAX    = STARVE_MAX_DEF
) (
  input  logic                     clk,
  input  logic                     xrst,
  input  logic                     host_req,
  input  logic                     host_we,
  input  logic [GOBOU_NETSIZE-1:0] host_addr,
  input  logic [DWIDTH-1:0]        host_wdata,
  output logic                     host_gnt,
  output logic                     host_rvalid,
  output logic [DWIDTH-1:0]        host_rdata,
  input  logic                     core_req,
  input  logic [GOBOU_NETSIZE-1:0] core_addr,
  input  logic                     core_lock,
  output logic                     core_gnt,
  output logic                     core_rvalid,
  output logic [DWIDTH-1:0]        core_rdata,
  output logic                     mem_we,
  output logic [GOBOU_NETSIZE-1:0] mem_addr,
  output logic [DWIDTH-1:0]        mem_wdata,
  input  logic [DWIDTH-1:0]        mem_rdata
);

  localparam int            SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  owner_e        r_last_owner;
  owner_e        r_rd_owner;
  logic [SW-1:0] r_starve_cnt;
  logic          w_host_gnt;
  logic          w_core_gnt;
  logic          w_starved;

  assign w_starved = (r_starve_cnt == STARVE_LIM);

  // Grants are suppressed during reset so no RAM access leaks out.
  always_comb begin
    w_host_gnt = 1'b0;
    w_core_gnt = 1'b0;
    if (xrst) begin
      if (host_req && core_req) begin
        if (w_starved)
          w_host_gnt = 1'b1;
        else if (core_lock && (r_last_owner == OWN_CORE))
          w_core_gnt = 1'b1;
        else if (r_last_owner == OWN_HOST)
          w_core_gnt = 1'b1;
        else
          w_host_gnt = 1'b1;
      end else begin
        w_host_gnt = host_req;
        w_core_gnt = core_req;
      end
    end
  end

  assign host_gnt = w_host_gnt;
  assign core_gnt = w_core_gnt;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_host_gnt) begin
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end else if (w_core_gnt) begin
      mem_addr  = core_addr;
    end
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_last_owner <= OWN_HOST;
      r_rd_owner   <= OWN_NONE;
      r_starve_cnt <= '0;
    end else begin
      if (w_host_gnt)
        r_last_owner <= OWN_HOST;
      else if (w_core_gnt)
        r_last_owner <= OWN_CORE;

      if (host_req && !w_host_gnt) begin
        if (!w_starved)
          r_starve_cnt <= r_starve_cnt + 1'b1;
      end else begin
        r_starve_cnt <= '0;
      end

      // Host writes return nothing, so they leave the read path idle.
      if (w_host_gnt && !host_we)
        r_rd_owner <= OWN_HOST;
      else if (w_core_gnt)
        r_rd_owner <= OWN_CORE;
      else
        r_rd_owner <= OWN_NONE;
    end
  end

  assign host_rvalid = (r_rd_owner == OWN_HOST);
  assign core_rvalid = (r_rd_owner == OWN_CORE);
  assign host_rdata  = mem_rdata;
  assign core_rdata  = mem_rdata;

endmodule

// File: tb/tb_gobou_net_arb.sv
// tb/tb_gobou_net_arb.sv - directed self-checking bench for gobou_net_arb
module tb_gobou_net_arb;

  localparam int DW   = 16;
  localparam int AW   = 8;
  localparam int SMAX = 15;

  logic          clk = 1'b0;
  logic          xrst;
  logic          host_req, host_we, host_gnt, host_rvalid;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic          core_req, core_lock, core_gnt, core_rvalid;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  gobou_net_arb #(
    .DWIDTH       (DW),
    .GOBOU_NETSIZE(AW),
    .STARVE_MAX   (SMAX)
  ) dut (
    .clk        (clk),
    .xrst       (xrst),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_gnt   (host_gnt),
    .host_rvalid(host_rvalid),
    .host_rdata (host_rdata),
    .core_req   (core_req),
    .core_addr  (core_addr),
    .core_lock  (core_lock),
    .core_gnt   (core_gnt),
    .core_rvalid(core_rvalid),
    .core_rdata (core_rdata),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Single-port RAM, registered address, write-first; reloads C000+addr in reset.
  logic [DW-1:0] ram [0:255];
  logic [AW-1:0] r_ram_addr;
  always @(posedge clk) begin
    if (!xrst) begin
      for (int i = 0; i < 256; i++) ram[i] <= DW'(32'hC000 + i);
      r_ram_addr <= '0;
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      r_ram_addr <= mem_addr;
    end
  end
  assign mem_rdata = ram[r_ram_addr];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    core_req = 1'b0; core_lock = 1'b0; core_addr = '0;
  endtask

  task automatic do_reset();
    xrst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 xrst = 1'b1;
  endtask

  task automatic test_reset();
    xrst = 1'b0;
    idle_inputs();
    host_req = 1'b1; core_req = 1'b1; host_we = 1'b1; host_addr = 8'd9;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (host_rvalid !== 1'b0 || core_rvalid !== 1'b0) begin
      $display("FAIL reset_rvalid host=%0b core=%0b want 0/0", host_rvalid, core_rvalid); n_errors++; end
    n_checks++; if (host_gnt !== 1'b0 || core_gnt !== 1'b0) begin
      $display("FAIL reset_gnt host=%0b core=%0b want 0/0", host_gnt, core_gnt); n_errors++; end
    n_checks++; if (mem_we !== 1'b0 || mem_addr !== '0) begin
      $display("FAIL reset_mem we=%0b addr=%0d want 0/0", mem_we, mem_addr); n_errors++; end
    idle_inputs();
    xrst = 1'b1;
  endtask

  task automatic test_host_only();
    cyc();
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'd5; host_wdata = 16'h1234;
    #1;
    n_checks++; if (host_gnt !== 1'b1 || core_gnt !== 1'b0) begin
      $display("FAIL host_wr_gnt host=%0b core=%0b want 1/0", host_gnt, core_gnt); n_errors++; end
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 8'd5 || mem_wdata !== 16'h1234) begin
      $display("FAIL host_wr_mem we=%0b addr=%0d wdata=%h want 1/5/1234", mem_we, mem_addr, mem_wdata); n_errors++; end
    cyc();
    host_we = 1'b0; host_wdata = '0;
    #1;
    n_checks++; if (host_gnt !== 1'b1 || mem_we !== 1'b0) begin
      $display("FAIL host_rd_gnt gnt=%0b we=%0b want 1/0", host_gnt, mem_we); n_errors++; end
    n_checks++; if (host_rvalid !== 1'b0) begin
      $display("FAIL host_wr_no_rvalid got %0b want 0", host_rvalid); n_errors++; end
    cyc();
    host_req = 1'b0;
    #1;
    n_checks++; if (host_rvalid !== 1'b1 || host_rdata !== 16'h1234 || core_rvalid !== 1'b0) begin
      $display("FAIL host_rd_data rvalid=%0b data=%h core_rvalid=%0b want 1/1234/0", host_rvalid, host_rdata, core_rvalid); n_errors++; end
    n_checks++; if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
      $display("FAIL idle_mem we=%0b addr=%0d wdata=%h want 0/0/0", mem_we, mem_addr, mem_wdata); n_errors++; end
    cyc();
    #1;
    n_checks++; if (host_rvalid !== 1'b0) begin
      $display("FAIL host_rvalid_drop got %0b want 0", host_rvalid); n_errors++; end
  endtask

  task automatic test_contention();
    do_reset();
    cyc();
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'd7;
    core_req = 1'b1; core_addr = 8'd3;
    #1;
    n_checks++; if (core_gnt !== 1'b1 || host_gnt !== 1'b0 || mem_addr !== 8'd3) begin
      $display("FAIL cont_first core=%0b host=%0b addr=%0d want 1/0/3", core_gnt, host_gnt, mem_addr); n_errors++; end
    cyc();
    core_req = 1'b0;
    #1;
    n_checks++; if (host_gnt !== 1'b1 || mem_addr !== 8'd7) begin
      $display("FAIL cont_second host=%0b addr=%0d want 1/7", host_gnt, mem_addr); n_errors++; end
    n_checks++; if (core_rvalid !== 1'b1 || core_rdata !== 16'hC003 || host_rvalid !== 1'b0) begin
      $display("FAIL cont_core_data rvalid=%0b data=%h host_rvalid=%0b want 1/C003/0", core_rvalid, core_rdata, host_rvalid); n_errors++; end
    cyc();
    host_req = 1'b0;
    #1;
    n_checks++; if (host_rvalid !== 1'b1 || host_rdata !== 16'hC007 || core_rvalid !== 1'b0) begin
      $display("FAIL cont_host_data rvalid=%0b data=%h core_rvalid=%0b want 1/C007/0", host_rvalid, host_rdata, core_rvalid); n_errors++; end
  endtask

  task automatic test_round_robin();
    logic          exp_core;
    logic [DW-1:0] exp_data;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc();
      host_req = 1'b1; host_we = 1'b0; host_addr = AW'(32 + i);
      core_req = 1'b1; core_addr = AW'(16 + i);
      #1;
      exp_core = (i % 2 == 0);
      n_checks++; if (core_gnt !== exp_core || host_gnt !== !exp_core) begin
        $display("FAIL rr_gnt_%0d core=%0b host=%0b want %0b/%0b", i, core_gnt, host_gnt, exp_core, !exp_core); n_errors++; end
      if (i > 0) begin
        if (!exp_core) begin
          exp_data = DW'(32'hC000 + 16 + i - 1);
          n_checks++; if (core_rvalid !== 1'b1 || host_rvalid !== 1'b0 || core_rdata !== exp_data) begin
            $display("FAIL rr_val_%0d core_rv=%0b host_rv=%0b data=%h want 1/0/%h", i, core_rvalid, host_rvalid, core_rdata, exp_data); n_errors++; end
        end else begin
          exp_data = DW'(32'hC000 + 32 + i - 1);
          n_checks++; if (host_rvalid !== 1'b1 || core_rvalid !== 1'b0 || host_rdata !== exp_data) begin
            $display("FAIL rr_val_%0d host_rv=%0b core_rv=%0b data=%h want 1/0/%h", i, host_rvalid, core_rvalid, host_rdata, exp_data); n_errors++; end
        end
      end
    end
    cyc();
    idle_inputs();
    #1;
    n_checks++; if (host_rvalid !== 1'b1 || host_rdata !== 16'hC025) begin
      $display("FAIL rr_last host_rv=%0b data=%h want 1/C025", host_rvalid, host_rdata); n_errors++; end
  endtask

  task automatic test_lock();
    logic exp_host;
    do_reset();
    for (int k = 1; k <= 18; k++) begin
      cyc();
      host_req = 1'b1; host_we = 1'b0; host_addr = 8'd1;
      core_req = 1'b1; core_lock = 1'b1; core_addr = 8'd2;
      #1;
      exp_host = (k == 16);
      n_checks++; if (host_gnt !== exp_host || core_gnt !== !exp_host) begin
        $display("FAIL lock_gnt_%0d host=%0b core=%0b want %0b/%0b", k, host_gnt, core_gnt, exp_host, !exp_host); n_errors++; end
    end
    cyc();
    core_req = 1'b0; core_lock = 1'b1; host_req = 1'b1;
    #1;
    n_checks++; if (host_gnt !== 1'b1 || core_gnt !== 1'b0) begin
      $display("FAIL lock_no_req host=%0b core=%0b want 1/0", host_gnt, core_gnt); n_errors++; end
    cyc();
    idle_inputs();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    cyc();
    core_req = 1'b1; core_addr = 8'd2;
    #1;
    n_checks++; if (core_gnt !== 1'b1) begin
      $display("FAIL mid_gnt got %0b want 1", core_gnt); n_errors++; end
    cyc();
    core_req = 1'b0;
    #1;
    n_checks++; if (core_rvalid !== 1'b1) begin
      $display("FAIL mid_pre_rvalid got %0b want 1", core_rvalid); n_errors++; end
    xrst = 1'b0;
    #1;
    n_checks++; if (core_rvalid !== 1'b0) begin
      $display("FAIL mid_rvalid_drop got %0b want 0", core_rvalid); n_errors++; end
    host_req = 1'b1; host_we = 1'b1; core_req = 1'b1; core_addr = 8'd4;
    #1;
    n_checks++; if (host_gnt !== 1'b0 || core_gnt !== 1'b0 || mem_we !== 1'b0) begin
      $display("FAIL mid_no_access host=%0b core=%0b we=%0b want 0/0/0", host_gnt, core_gnt, mem_we); n_errors++; end
    cyc();
    xrst = 1'b1;
    #1;
    n_checks++; if (core_gnt !== 1'b1 || host_gnt !== 1'b0) begin
      $display("FAIL mid_after_core core=%0b host=%0b want 1/0", core_gnt, host_gnt); n_errors++; end
    cyc();
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_data;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc();
      core_req = 1'b1; core_addr = AW'(40 + i);
      #1;
      n_checks++; if (core_gnt !== 1'b1 || mem_addr !== AW'(40 + i)) begin
        $display("FAIL b2b_gnt_%0d gnt=%0b addr=%0d want 1/%0d", i, core_gnt, mem_addr, 40 + i); n_errors++; end
      if (i > 0) begin
        exp_data = DW'(32'hC000 + 40 + i - 1);
        n_checks++; if (core_rvalid !== 1'b1 || core_rdata !== exp_data) begin
          $display("FAIL b2b_data_%0d rv=%0b data=%h want 1/%h", i, core_rvalid, core_rdata, exp_data); n_errors++; end
      end
    end
    cyc();
    core_req = 1'b0;
    #1;
    n_checks++; if (core_rvalid !== 1'b1 || core_rdata !== 16'hC02F) begin
      $display("FAIL b2b_last rv=%0b data=%h want 1/C02F", core_rvalid, core_rdata); n_errors++; end
    cyc();
    #1;
    n_checks++; if (core_rvalid !== 1'b0) begin
      $display("FAIL b2b_end rv=%0b want 0", core_rvalid); n_errors++; end
  endtask

  initial begin
    test_reset();
    test_host_only();
    test_contention();
    test_round_robin();
    test_lock();
    test_reset_mid_burst();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
